riscv_mem_arbiter: RTL and testbench
====================================

RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128: block width in bits (one cache line).
REQ-002 SHALL have parameter MEM_DEPTH, default 1024: number of DATA_WIDTH-bit blocks stored.
REQ-003 SHALL have parameter S_ADDR, default $clog2(MEM_DEPTH): block-address width.
REQ-004 SHALL have parameter LATENCY, default 4: ACCESS-state cycles per transfer, legal range 1..15.
REQ-005 SHALL have port i_riscv_memarb_clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port i_riscv_memarb_rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port i_riscv_memarb_d_rden, input, 1: data-cache refill request.
REQ-008 SHALL have port i_riscv_memarb_d_wren, input, 1: data-cache write-back request.
REQ-009 SHALL have port i_riscv_memarb_d_addr, input, S_ADDR: data-side block address.
REQ-010 SHALL have port i_riscv_memarb_d_data_in, input, DATA_WIDTH: write-back block.
REQ-011 SHALL have port o_riscv_memarb_d_data_out, output, DATA_WIDTH: data-side read block.
REQ-012 SHALL have port o_riscv_memarb_d_mem_ready, output, 1: data-side completion pulse.
REQ-013 SHALL have port i_riscv_memarb_i_rden, input, 1: instruction-cache refill request.
REQ-014 SHALL have port i_riscv_memarb_i_addr, input, S_ADDR: instruction-side block address.
REQ-015 SHALL have port o_riscv_memarb_i_data_out, output, DATA_WIDTH: instruction-side read block.
REQ-016 SHALL have port o_riscv_memarb_i_mem_ready, output, 1: instruction-side completion pulse.
REQ-017 SHALL have port o_riscv_memarb_busy, output, 1: high in every state except IDLE.

Function
REQ-018 SHALL act as the responder for both cache refill FSMs: each initiator holds its request, address and data stable until its mem_ready pulse.
REQ-019 SHALL implement the FSM IDLE -> ACCESS -> RESP -> GAP -> IDLE; ACCESS lasts exactly LATENCY cycles, RESP and GAP one cycle each.
REQ-020 SHALL, in IDLE, grant a pending port and at that edge latch the port, operation, address and write data.
REQ-021 SHALL, when a request is sampled at edge N, hold the granted port's mem_ready high only between edges N+LATENCY and N+LATENCY+1.
REQ-022 SHALL commit a write to the array, or load the read block into that port's data_out register, at the ACCESS->RESP edge.
REQ-023 SHALL hold each data_out register until that port's next read completes; a write leaves data_out unchanged.
REQ-024 SHALL ignore all requests during ACCESS, RESP and GAP; GAP lets the initiator drop its request.
REQ-025 SHALL treat d_wren and d_rden asserted together as a write and ignore the read.
REQ-026 SHALL give back-to-back throughput of one transfer per LATENCY+3 cycles.
REQ-027 SHALL use only the latched address and data, so input changes after the grant have no effect.

Reset
REQ-028 SHALL, with rst_n low, force IDLE, the latency counter to 0, both mem_ready outputs to 0, both data_out outputs to 0, busy to 0 and the round-robin pointer to the D port.
REQ-029 SHALL, if reset asserts before the ACCESS->RESP edge, abort the transfer with no array write and no mem_ready pulse.
REQ-030 SHALL not clear array contents on reset.

Configuration
REQ-031 SHALL, with RISCV_MEMARB_RR_EN defined, arbitrate round-robin: on a D/I tie grant the port not served last, and update the pointer at each grant.
REQ-032 SHALL, without RISCV_MEMARB_RR_EN, use fixed priority on a tie: the D port always wins and no pointer register exists.

Verification
REQ-033 SHALL check a single write: LATENCY=4, d_wren with addr 0x05 and data 0xDEADBEEF_00000000_CAFEF00D_12345678 sampled at edge 10 -> d_mem_ready high only in cycle 14-15, then a d_rden to 0x05 returns that data.
REQ-034 SHALL check a single read: i_rden to 0x3FF after preload 0xA5 repeated -> i_data_out=0xA5A5...A5 and i_mem_ready pulsed once, with d_data_out unchanged.
REQ-035 SHALL check a tie: d_rden and i_rden both sampled at edge 20 -> without the macro D is served first (ready edge 24), then I (grant edge 27, ready edge 31); with the macro the second tie after D goes to I.
REQ-036 SHALL check simultaneous d_rden and d_wren to 0x10: a write occurs and d_data_out is unchanged.
REQ-037 SHALL check reset mid-operation: rst_n low for 1 cycle during ACCESS of a write to 0x07 -> no ready pulse, 0x07 keeps its old value, and the FSM is in IDLE.
REQ-038 SHALL check back-to-back held requests on the I port: consecutive i_mem_ready pulses are exactly 7 cycles apart.

Source files
------------

// File: rtl/riscv_mem_arbiter_if.sv
// Cache-side bus of riscv_mem_arbiter: D-cache refill/write-back port, I-cache refill port
// and the shared busy flag. The cache side uses master, the arbiter uses slave.
interface riscv_mem_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned S_ADDR     = 10
);

    logic                  i_riscv_memarb_d_rden;
    logic                  i_riscv_memarb_d_wren;
    logic [S_ADDR-1:0]     i_riscv_memarb_d_addr;
    logic [DATA_WIDTH-1:0] i_riscv_memarb_d_data_in;
    logic [DATA_WIDTH-1:0] o_riscv_memarb_d_data_out;
    logic                  o_riscv_memarb_d_mem_ready;

    logic                  i_riscv_memarb_i_rden;
    logic [S_ADDR-1:0]     i_riscv_memarb_i_addr;
    logic [DATA_WIDTH-1:0] o_riscv_memarb_i_data_out;
    logic                  o_riscv_memarb_i_mem_ready;

    logic                  o_riscv_memarb_busy;

    modport master (
        output i_riscv_memarb_d_rden, i_riscv_memarb_d_wren, i_riscv_memarb_d_addr,
               i_riscv_memarb_d_data_in, i_riscv_memarb_i_rden, i_riscv_memarb_i_addr,
        input  o_riscv_memarb_d_data_out, o_riscv_memarb_d_mem_ready,
               o_riscv_memarb_i_data_out, o_riscv_memarb_i_mem_ready, o_riscv_memarb_busy
    );

    modport slave (
        input  i_riscv_memarb_d_rden, i_riscv_memarb_d_wren, i_riscv_memarb_d_addr,
               i_riscv_memarb_d_data_in, i_riscv_memarb_i_rden, i_riscv_memarb_i_addr,
        output o_riscv_memarb_d_data_out, o_riscv_memarb_d_mem_ready,
               o_riscv_memarb_i_data_out, o_riscv_memarb_i_mem_ready, o_riscv_memarb_busy
    );

endinterface

// File: rtl/riscv_mem_arbiter.sv
// Shared block memory serving the D- and I-cache refill FSMs, one transfer at a time.
// Define RISCV_MEMARB_RR_EN for round-robin tie-breaking; otherwise D always wins a tie.
module riscv_mem_arbiter #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned MEM_DEPTH  = 1024,
    parameter int unsigned S_ADDR     = $clog2(MEM_DEPTH),
    parameter int unsigned LATENCY    = 4
) (
    input logic                i_riscv_memarb_clk,
    input logic                i_riscv_memarb_rst_n,
    riscv_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp, StGap} state_e;

    localparam logic [3:0] LastCnt = 4'(LATENCY - 1);

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic                  port_q;  // 1: I port owns the current transfer
    logic                  wr_q;
    logic [S_ADDR-1:0]     addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] d_rdata_q;
    logic [DATA_WIDTH-1:0] i_rdata_q;
    logic                  d_ready_q;
    logic                  i_ready_q;
    logic                  busy_q;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic d_req;
    logic i_req;
    logic grant_i;
    logic access_done;

    assign d_req       = bus.i_riscv_memarb_d_rden | bus.i_riscv_memarb_d_wren;
    assign i_req       = bus.i_riscv_memarb_i_rden;
    assign access_done = (state_q == StAccess) && (cnt_q == LastCnt);

`ifdef RISCV_MEMARB_RR_EN
    logic rr_q;  // 1: I port has priority on the next tie

    assign grant_i = i_req & (~d_req | rr_q);

    always_ff @(posedge i_riscv_memarb_clk or negedge i_riscv_memarb_rst_n) begin
        if (!i_riscv_memarb_rst_n) begin
            rr_q <= 1'b0;
        end else if (state_q == StIdle && (d_req || i_req)) begin
            rr_q <= ~grant_i;
        end
    end
`else
    assign grant_i = i_req & ~d_req;
`endif

    always_ff @(posedge i_riscv_memarb_clk or negedge i_riscv_memarb_rst_n) begin
        if (!i_riscv_memarb_rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            port_q    <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            d_rdata_q <= '0;
            i_rdata_q <= '0;
            d_ready_q <= 1'b0;
            i_ready_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            d_ready_q <= 1'b0;
            i_ready_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (d_req || i_req) begin
                        state_q <= StAccess;
                        busy_q  <= 1'b1;
                        cnt_q   <= 4'd0;
                        port_q  <= grant_i;
                        // A combined D read+write is a write; the read is dropped.
                        wr_q    <= ~grant_i & bus.i_riscv_memarb_d_wren;
                        addr_q  <= grant_i ? bus.i_riscv_memarb_i_addr
                                           : bus.i_riscv_memarb_d_addr;
                        wdata_q <= bus.i_riscv_memarb_d_data_in;
                    end
                end
                StAccess: begin
                    if (cnt_q == LastCnt) begin
                        state_q <= StResp;
                        if (port_q) begin
                            i_ready_q <= 1'b1;
                            i_rdata_q <= mem_q[addr_q];
                        end else begin
                            d_ready_q <= 1'b1;
                            if (!wr_q) begin
                                d_rdata_q <= mem_q[addr_q];
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StResp: begin
                    state_q <= StGap;
                    cnt_q   <= 4'd0;
                end
                StGap: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Array is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge i_riscv_memarb_clk) begin
        if (access_done && wr_q) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign bus.o_riscv_memarb_d_data_out  = d_rdata_q;
    assign bus.o_riscv_memarb_i_data_out  = i_rdata_q;
    assign bus.o_riscv_memarb_d_mem_ready = d_ready_q;
    assign bus.o_riscv_memarb_i_mem_ready = i_ready_q;
    assign bus.o_riscv_memarb_busy        = busy_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter (LATENCY=4): timing of mem_ready, data paths,
// tie-breaking, combined read/write, reset abort and back-to-back throughput.
module tb_riscv_mem_arbiter;

    localparam int unsigned Dw = 128;
    localparam int unsigned Aw = 10;

`ifdef RISCV_MEMARB_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    localparam logic [Dw-1:0] DataDb  = 128'hDEADBEEF_00000000_CAFEF00D_12345678;
    localparam logic [Dw-1:0] DataA5  = {16{8'hA5}};
    localparam logic [Dw-1:0] DataC3  = {16{8'hC3}};
    localparam logic [Dw-1:0] DataOld = 128'h01234567_89ABCDEF_00112233_44556677;
    localparam logic [Dw-1:0] DataNew = 128'hFEDCBA98_76543210_FFEEDDCC_BBAA9988;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    riscv_mem_arbiter_if #(.DATA_WIDTH(Dw), .S_ADDR(Aw)) bus ();

    riscv_mem_arbiter #(
        .DATA_WIDTH(Dw),
        .MEM_DEPTH (1024),
        .S_ADDR    (Aw),
        .LATENCY   (4)
    ) dut (
        .i_riscv_memarb_clk  (clk),
        .i_riscv_memarb_rst_n(rst_n),
        .bus                 (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [Dw-1:0] got, input logic [Dw-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drop_all();
        bus.i_riscv_memarb_d_rden = 1'b0;
        bus.i_riscv_memarb_d_wren = 1'b0;
        bus.i_riscv_memarb_i_rden = 1'b0;
    endtask

    // Offsets are counted in edges from the edge that samples the request (offset 0).
    task automatic run_xfer(input logic d_rd, input logic d_wr, input logic i_rd,
                            input logic [Aw-1:0] d_a, input logic [Aw-1:0] i_a,
                            input logic [Dw-1:0] wd,
                            output int d_off, output int i_off, output int d_n, output int i_n);
        d_off = -1;
        i_off = -1;
        d_n   = 0;
        i_n   = 0;
        @(negedge clk);
        bus.i_riscv_memarb_d_rden    = d_rd;
        bus.i_riscv_memarb_d_wren    = d_wr;
        bus.i_riscv_memarb_i_rden    = i_rd;
        bus.i_riscv_memarb_d_addr    = d_a;
        bus.i_riscv_memarb_i_addr    = i_a;
        bus.i_riscv_memarb_d_data_in = wd;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_riscv_memarb_d_mem_ready) begin
                if (d_n == 0) d_off = k;
                d_n++;
                bus.i_riscv_memarb_d_rden = 1'b0;
                bus.i_riscv_memarb_d_wren = 1'b0;
            end
            if (bus.o_riscv_memarb_i_mem_ready) begin
                if (i_n == 0) i_off = k;
                i_n++;
                bus.i_riscv_memarb_i_rden = 1'b0;
            end
        end
        drop_all();
    endtask

    initial begin
        int d_off, i_off, d_n, i_n;
        int e [3];
        int n;

        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        drop_all();
        bus.i_riscv_memarb_d_addr    = '0;
        bus.i_riscv_memarb_i_addr    = '0;
        bus.i_riscv_memarb_d_data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 128'(bus.o_riscv_memarb_busy), 128'd0);
        check("rst_d_rdy", 128'(bus.o_riscv_memarb_d_mem_ready), 128'd0);
        check("rst_i_rdy", 128'(bus.o_riscv_memarb_i_mem_ready), 128'd0);
        check("rst_d_out", bus.o_riscv_memarb_d_data_out, '0);
        check("rst_i_out", bus.o_riscv_memarb_i_data_out, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write then read-back on D.
        run_xfer(1'b0, 1'b1, 1'b0, 10'h005, 10'h000, DataDb, d_off, i_off, d_n, i_n);
        check("wr_rdy_off", 128'(d_off), 128'd4);
        check("wr_rdy_cnt", 128'(d_n), 128'd1);
        check("wr_d_out_kept", bus.o_riscv_memarb_d_data_out, '0);
        check("wr_i_none", 128'(i_n), 128'd0);
        run_xfer(1'b1, 1'b0, 1'b0, 10'h005, 10'h000, '0, d_off, i_off, d_n, i_n);
        check("rd_d_off", 128'(d_off), 128'd4);
        check("rd_d_data", bus.o_riscv_memarb_d_data_out, DataDb);

        // Preload 0x3FF, read it on I.
        run_xfer(1'b0, 1'b1, 1'b0, 10'h3FF, 10'h000, DataA5, d_off, i_off, d_n, i_n);
        run_xfer(1'b0, 1'b0, 1'b1, 10'h000, 10'h3FF, '0, d_off, i_off, d_n, i_n);
        check("rd_i_off", 128'(i_off), 128'd4);
        check("rd_i_cnt", 128'(i_n), 128'd1);
        check("rd_i_data", bus.o_riscv_memarb_i_data_out, DataA5);
        check("rd_i_d_kept", bus.o_riscv_memarb_d_data_out, DataDb);

        // Tie right after an I grant: D first under both policies.
        run_xfer(1'b1, 1'b0, 1'b1, 10'h005, 10'h3FF, '0, d_off, i_off, d_n, i_n);
        check("tie1_d_off", 128'(d_off), 128'd4);
        check("tie1_i_off", 128'(i_off), 128'd11);
        check("tie1_d_data", bus.o_riscv_memarb_d_data_out, DataDb);

        // Combined read+write to 0x10 is a write.
        run_xfer(1'b1, 1'b1, 1'b0, 10'h010, 10'h000, DataC3, d_off, i_off, d_n, i_n);
        check("rw_d_off", 128'(d_off), 128'd4);
        check("rw_d_out_kept", bus.o_riscv_memarb_d_data_out, DataDb);

        // Tie right after a D grant: round-robin hands it to I.
        run_xfer(1'b1, 1'b0, 1'b1, 10'h010, 10'h005, '0, d_off, i_off, d_n, i_n);
        check("tie2_d_off", 128'(d_off), RrEn ? 128'd11 : 128'd4);
        check("tie2_i_off", 128'(i_off), RrEn ? 128'd4 : 128'd11);
        check("tie2_d_data", bus.o_riscv_memarb_d_data_out, DataC3);
        check("tie2_i_data", bus.o_riscv_memarb_i_data_out, DataDb);

        // Reset during ACCESS of a write to 0x07.
        run_xfer(1'b0, 1'b1, 1'b0, 10'h007, 10'h000, DataOld, d_off, i_off, d_n, i_n);
        @(negedge clk);
        bus.i_riscv_memarb_d_wren    = 1'b1;
        bus.i_riscv_memarb_d_addr    = 10'h007;
        bus.i_riscv_memarb_d_data_in = DataNew;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_mid_busy_pre", 128'(bus.o_riscv_memarb_busy), 128'd1);
        rst_n = 1'b0;
        drop_all();
        #1;
        check("rst_mid_busy_async", 128'(bus.o_riscv_memarb_busy), 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_riscv_memarb_d_mem_ready || bus.o_riscv_memarb_i_mem_ready) n++;
        end
        check("rst_mid_no_rdy", 128'(n), 128'd0);
        check("rst_mid_idle", 128'(bus.o_riscv_memarb_busy), 128'd0);
        check("rst_mid_d_out", bus.o_riscv_memarb_d_data_out, '0);
        run_xfer(1'b1, 1'b0, 1'b0, 10'h007, 10'h000, '0, d_off, i_off, d_n, i_n);
        check("rst_mid_old", bus.o_riscv_memarb_d_data_out, DataOld);
        run_xfer(1'b1, 1'b0, 1'b0, 10'h010, 10'h000, '0, d_off, i_off, d_n, i_n);
        check("rw_written", bus.o_riscv_memarb_d_data_out, DataC3);

        // Held I request: one transfer every LATENCY+3 cycles.
        e[0] = -100;
        e[1] = -200;
        e[2] = -300;
        n    = 0;
        @(negedge clk);
        bus.i_riscv_memarb_i_rden = 1'b1;
        bus.i_riscv_memarb_i_addr = 10'h3FF;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_riscv_memarb_i_mem_ready) begin
                if (n < 3) e[n] = k;
                n++;
            end
        end
        drop_all();
        check("b2b_first", 128'(e[0]), 128'd4);
        check("b2b_gap1", 128'(e[1] - e[0]), 128'd7);
        check("b2b_gap2", 128'(e[2] - e[1]), 128'd7);
        check("b2b_data", bus.o_riscv_memarb_i_data_out, DataA5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
